// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encodings.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: (WIDTH+1)-bit trial subtract built as a ripple of
// full subtractors, the borrow chain mirroring the ripple adder's carry chain.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_shifted,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] chain;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_full_sub
    assign diff[i]      = rem_shifted[i] ^ divisor[i] ^ chain[i];
    assign chain[i + 1] = (~rem_shifted[i] & divisor[i]) |
                          (~(rem_shifted[i] ^ divisor[i]) & chain[i]);
  end

  assign borrow = chain[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One trial subtraction per cycle; Q/R/DZ are registered only on entry to FIN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

  div_state_t state, state_next;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] div;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] qsr_next;
  logic             unused_rem_msb;

  // rem is always below the divisor, so its top bit is provably zero and only
  // the low WIDTH bits take part in the shift.
  assign rem_shifted    = {rem[WIDTH-1:0], qsr[WIDTH-1]};
  assign unused_rem_msb = rem[WIDTH];

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_shifted(rem_shifted),
    .divisor    ({1'b0, div}),
    .diff       (trial),
    .borrow     (borrow)
  );

  assign rem_next = borrow ? rem_shifted : trial;
  assign qsr_next = {qsr[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (start) begin
          state_next = (B == '0) ? DIV_FIN : DIV_RUN;
        end
      end
      DIV_RUN: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = DIV_FIN;
        end
      end
      DIV_FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = DIV_IDLE;
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  // Divide-by-zero bypasses RUN entirely and loads the result registers directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      qsr   <= '0;
      div   <= '0;
      count <= '0;
      Q     <= '0;
      R     <= '0;
      DZ    <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            if (B == '0) begin
              Q  <= '1;
              R  <= A;
              DZ <= 1'b1;
            end else begin
              rem   <= '0;
              qsr   <= A;
              div   <= B;
              count <= COUNT_INIT;
              DZ    <= 1'b0;
            end
          end
        end
        DIV_RUN: begin
          rem <= rem_next;
          qsr <= qsr_next;
          if (count == '0) begin
            Q <= qsr_next;
            R <= rem_next[WIDTH-1:0];
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8) using immediate assertions.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  seq_divider #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .busy (busy),
    .done (done),
    .Q    (q),
    .R    (r),
    .DZ   (dz)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s (A=%0d B=%0d): observed %0d expected %0d",
             tag, a_in, b_in, observed, expected);
    end
  endtask

  // Called at a falling edge: start is high for exactly one cycle.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_divide(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat;
    int           k;
    bit           busy_gap;
    if (b == 0) begin
      exp_q = '1; exp_r = a; exp_dz = 1'b1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = W + 1;
    end
    apply_stimulus(a, b);
    k = 1;
    busy_gap = 1'b0;
    if (b != 0) begin
      check_output("q_hold_run", q, prev_q);
      check_output("r_hold_run", r, prev_r);
    end
    while (!done && k < 3 * W) begin
      if (!busy) busy_gap = 1'b1;
      @(negedge clk);
      k++;
    end
    check_output("latency", k, exp_lat);
    check_output("busy_gap", busy_gap, 0);
    check_output("busy_at_done", busy, 1);
    check_output("quotient", q, exp_q);
    check_output("remainder", r, exp_r);
    check_output("dz", dz, exp_dz);
    prev_q = exp_q;
    prev_r = exp_r;
    @(negedge clk);
    check_output("done_one_pulse", done, 0);
    check_output("busy_after_done", busy, 0);
  endtask

  initial begin
    int           done_count;
    int           done_at;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    prev_q = '0;
    prev_r = '0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_q", q, 0);
    check_output("reset_r", r, 0);
    check_output("reset_dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic divides");
    run_divide(8'd100, 8'd7);
    run_divide(8'd255, 8'd1);
    run_divide(8'd5, 8'd9);
    run_divide(8'd200, 8'd200);
    run_divide(8'd0, 8'd3);

    $display("[TB] divide by zero then recovery");
    run_divide(8'd37, 8'd0);
    run_divide(8'd9, 8'd3);

    $display("[TB] start while busy is ignored");
    apply_stimulus(8'd100, 8'd7);
    done_count = 0;
    done_at = 0;
    cap_q = '0;
    cap_r = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        done_count++;
        done_at = k;
        cap_q = q;
        cap_r = r;
      end
      if (k == 4) begin
        a_in = 8'd1; b_in = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 11) check_output("no_queued_start", busy, 0);
    end
    a_in = 8'd100; b_in = 8'd7;
    check_output("busy_start_done_count", done_count, 1);
    check_output("busy_start_done_at", done_at, W + 1);
    check_output("busy_start_q", cap_q, 14);
    check_output("busy_start_r", cap_r, 2);
    prev_q = 8'd14;
    prev_r = 8'd2;

    $display("[TB] reset mid-divide");
    @(negedge clk);
    apply_stimulus(8'd100, 8'd7);
    done_count = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (done) done_count++;
      if (k == 5) rst = 1'b1;
    end
    check_output("midreset_busy", busy, 0);
    check_output("midreset_done", done, 0);
    check_output("midreset_q", q, 0);
    check_output("midreset_r", r, 0);
    check_output("midreset_dz", dz, 0);
    check_output("midreset_no_done", done_count, 0);
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    @(negedge clk);
    run_divide(8'd77, 8'd5);

    $display("[TB] reset wins over start");
    rst = 1'b1;
    a_in = 8'd50; b_in = 8'd5; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_output("rst_start_busy", busy, 0);
    check_output("rst_start_q", q, 0);
    @(negedge clk);
    check_output("rst_start_idle", busy, 0);
    prev_q = '0;
    prev_r = '0;

    $display("[TB] corner and random sweep");
    run_divide(8'd255, 8'd255);
    run_divide(8'd254, 8'd255);
    run_divide(8'd128, 8'd2);
    run_divide(8'd1, 8'd0);
    run_divide(8'd255, 8'd16);
    for (int i = 0; i < 200; i++) begin
      run_divide(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
